alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Next-generation execute-stage arithmetic block for the pipelined MIPS CPU.
- Parametrised-width combinational ALU with an extended op set.
- Adds a multi-cycle multiply/divide unit (MDU) with HI/LO registers and a Start/Busy handshake, which the hazard unit uses to stall.
- Sits in the EX stage. C goes to EX/MEM; HI/LO feed mfhi/mflo.

Parameters:
- WIDTH, 32: datapath width. Must be a power of 2, at least 8.
- MUL_CYCLES, 5: number of cycles Busy stays high for MULT/MULTU.
- DIV_CYCLES, 10: number of cycles Busy stays high for DIV/DIVU.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt or immediate).
- Shamt  input  log2(WIDTH)  shift amount.
- ALUOp  input  4  ALU operation select.
- Start  input  1  one-cycle MDU command strobe.
- MDOp  input  3  MDU operation select, sampled when Start=1.
- C  output  WIDTH  ALU result, combinational.
- Equal  output  1  A==B, combinational.
- Overflow  output  1  signed overflow flag (see Optional Feature).
- Busy  output  1  MDU computing, registered.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- ALUOp encoding and result C:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 OR
  - 3 SLL: B<<Shamt
  - 4 AND
  - 5 XOR
  - 6 NOR
  - 7 SRL: B>>Shamt, logical
  - 8 SRA: B>>>Shamt, arithmetic
  - 9 SLT: signed A<B gives 1, else 0
  - 10 SLTU: unsigned compare, 1 or 0
  - 11 LUI: B<<(WIDTH/2)
  - 12-15: C = all ones
- All ALU arithmetic is modulo 2^WIDTH.
- ALU path is purely combinational and independent of clk, reset and Busy.
- MDOp encoding:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU: computing ops.
  - 4 MTHI, 5 MTLO: move-to ops.
  - 6-7: ignored.
- Reset, on any clk edge with reset=1:
  - Busy=0, HI=0, LO=0, cycle counter=0.
  - Any operation in flight is aborted; its result is never written.
- MDU states: IDLE and RUN.
  - IDLE, Start=1 with MDOp 0-3: latch A, B and MDOp at the edge; load counter with MUL_CYCLES or DIV_CYCLES; go to RUN; Busy=1 from the next cycle.
  - IDLE, Start=1 with MTHI: HI<=A at the edge. MTLO: LO<=A at the edge. Busy stays 0.
  - RUN: counter decrements each cycle. On the edge where the counter reaches 1: write HI/LO, Busy<=0, go to IDLE.
  - Result: Busy high for exactly N cycles; HI/LO hold the new values in the first cycle with Busy=0.
- Start while Busy=1, including MTHI/MTLO, is ignored. HI and LO stay stable during RUN.
- Start in the same cycle Busy falls is accepted, since the FSM is already IDLE by then.
- MULT/MULTU: {HI,LO} = signed or unsigned 2*WIDTH-bit product.
- DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero: full DIV_CYCLES of Busy, then HI and LO unchanged.
- Signed DIV of most-negative value by -1: LO = most-negative value, HI = 0.
- Result computation may be done at latch time or iteratively. Only the write-back timing above is observable.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: Overflow=1 when ALUOp is ADD or SUB and the signed result overflows WIDTH bits. Otherwise 0. Combinational; C is still the wrapped value.
- Undefined: Overflow is tied to 0 and no detection logic is built.

Test Plan:
- WIDTH=32, MULT A=0xFFFFFFFF, B=2 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 10 Busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 -> 10 Busy cycles, then HI and LO keep their prior values. During RUN, Start with MTLO A=5 -> LO unchanged.
- MULT in flight, reset asserted at cycle 3 -> next cycle Busy=0, HI=0, LO=0; no late write-back afterwards.
- ALU checks:
  - SRA B=0x80000000, Shamt=4 -> C=0xF8000000.
  - SLT A=0xFFFFFFFF, B=1 -> C=1; SLTU with the same operands -> C=0.
  - With ALU_OVF_EN: ADD 0x7FFFFFFF+1 -> C=0x80000000, Overflow=1.

Source files
------------

// File: rtl/alu_mdu.sv
// EX-stage ALU with a multi-cycle multiply/divide unit and HI/LO registers.
// Define ALU_OVF_EN to build signed-overflow detection for ADD/SUB.
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic [$clog2(WIDTH)-1:0] Shamt,
  input  logic [3:0]               ALUOp,
  input  logic                     Start,
  input  logic [2:0]               MDOp,
  output logic [WIDTH-1:0]         C,
  output logic                     Equal,
  output logic                     Overflow,
  output logic                     Busy,
  output logic [WIDTH-1:0]         HI,
  output logic [WIDTH-1:0]         LO
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int MSB     = WIDTH - 1;

  // Full-width product; sign extension to 2*WIDTH makes the modulo product exact.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sgn);
    logic [2*WIDTH-1:0] ea, eb;
    ea = sgn ? {{WIDTH{a[MSB]}}, a} : {{WIDTH{1'b0}}, a};
    eb = sgn ? {{WIDTH{b[MSB]}}, b} : {{WIDTH{1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}; signed case divides magnitudes so that
  // MIN / -1 wraps to MIN with zero remainder instead of trapping.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sgn);
    logic              na, nb;
    logic [WIDTH-1:0]  ma, mb, q, r, quo, rem;
    na  = sgn & a[MSB];
    nb  = sgn & b[MSB];
    ma  = na ? (~a + 1'b1) : a;
    mb  = nb ? (~b + 1'b1) : b;
    q   = ma / mb;
    r   = ma % mb;
    quo = (na ^ nb) ? (~q + 1'b1) : q;
    rem = na ? (~r + 1'b1) : r;
    return {rem, quo};
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s;
  logic        [WIDTH-1:0] sum, diff;

  assign a_s   = A;
  assign b_s   = B;
  assign sum   = A + B;
  assign diff  = A - B;
  assign Equal = (A == B);

  always_comb begin
    C = '1;
    case (ALUOp)
      4'd0:    C = sum;
      4'd1:    C = diff;
      4'd2:    C = A | B;
      4'd3:    C = B << Shamt;
      4'd4:    C = A & B;
      4'd5:    C = A ^ B;
      4'd6:    C = ~(A | B);
      4'd7:    C = B >> Shamt;
      4'd8:    C = b_s >>> Shamt;
      4'd9:    C = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      4'd10:   C = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd11:   C = B << (WIDTH / 2);
      default: C = '1;
    endcase
  end

`ifdef ALU_OVF_EN
  always_comb begin
    Overflow = 1'b0;
    case (ALUOp)
      4'd0:    Overflow = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      4'd1:    Overflow = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      default: Overflow = 1'b0;
    endcase
  end
`else
  assign Overflow = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_p0, b_p0;
  logic [1:0]         op_p0;
  logic [2*WIDTH-1:0] res;
  logic               div_zero;

  // Result is derived from the operands captured at command time.
  always_comb begin
    res = op_p0[1] ? div_full(a_p0, b_p0, ~op_p0[0])
                   : mul_full(a_p0, b_p0, ~op_p0[0]);
  end
  assign div_zero = op_p0[1] && (b_p0 == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            case (MDOp)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                a_p0  <= A;
                b_p0  <= B;
                op_p0 <= MDOp[1:0];
                cnt   <= MDOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                state <= RUN;
                Busy  <= 1'b1;
              end
              3'd4:    HI <= A;
              3'd5:    LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            if (!div_zero) begin
              HI <= res[2*WIDTH-1:WIDTH];
              LO <= res[WIDTH-1:0];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: combinational ALU table plus MDU scoreboard.
// Builds with or without ALU_OVF_EN; overflow expectations follow the macro.
module tb_alu_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A, B;
  logic [4:0]   Shamt;
  logic [3:0]   ALUOp;
  logic         Start;
  logic [2:0]   MDOp;
  logic [W-1:0] C;
  logic         Equal, Overflow, Busy;
  logic [W-1:0] HI, LO;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           n;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] hi_m, lo_m;

  alu_mdu #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Shamt(Shamt), .ALUOp(ALUOp),
    .Start(Start), .MDOp(MDOp), .C(C), .Equal(Equal), .Overflow(Overflow),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic alu(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] exp_c);
    ALUOp = op; A = a; B = b; Shamt = sh;
    #1;
    chk(tag, 64'(C), 64'(exp_c));
  endtask

  // Issue an MDU command at the current (post-edge) time and follow it to completion.
  task automatic mdu(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                     input int n, input bit inject_mtlo);
    exp_t e;
    int   cnt;
    e.hi = ehi; e.lo = elo; e.n = n;
    sb.push_back(e);
    A = a; B = b; MDOp = op; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    chk({tag, "_busy_rise"}, 64'(Busy), 64'(1));
    cnt = 0;
    while (Busy === 1'b1 && cnt < 200) begin
      cnt++;
      chk({tag, "_hi_stable"}, 64'(HI), 64'(hi_m));
      chk({tag, "_lo_stable"}, 64'(LO), 64'(lo_m));
      if (inject_mtlo && cnt == 2) begin
        Start = 1'b1; MDOp = 3'd5; A = 32'd5;
      end else begin
        Start = 1'b0;
      end
      @(posedge clk); #1;
    end
    Start = 1'b0;
    e = sb.pop_front();
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(e.n));
    chk({tag, "_hi"}, 64'(HI), 64'(e.hi));
    chk({tag, "_lo"}, 64'(LO), 64'(e.lo));
    hi_m = e.hi;
    lo_m = e.lo;
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = '0; A = '0; B = '0; Shamt = '0; ALUOp = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_hi", 64'(HI), 64'(0));
    chk("rst_lo", 64'(LO), 64'(0));

    // ALU directed table
    alu("add",     4'd0,  32'd5,        32'd3,        5'd0,  32'd8);
    alu("add_wrap",4'd0,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd0);
    alu("sub",     4'd1,  32'd3,        32'd5,        5'd0,  32'hFFFFFFFE);
    alu("or",      4'd2,  32'h0000F0F0, 32'h00000F00, 5'd0,  32'h0000FFF0);
    alu("sll",     4'd3,  32'd0,        32'd1,        5'd31, 32'h80000000);
    alu("and",     4'd4,  32'hFF00FF00, 32'h0FF00FF0, 5'd0,  32'h0F000F00);
    alu("xor",     4'd5,  32'hFF00FF00, 32'h0FF00FF0, 5'd0,  32'hF0F0F0F0);
    alu("nor0",    4'd6,  32'd0,        32'd0,        5'd0,  32'hFFFFFFFF);
    alu("nor1",    4'd6,  32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0,  32'h00000000);
    alu("srl",     4'd7,  32'd0,        32'h80000000, 5'd4,  32'h08000000);
    alu("sra",     4'd8,  32'd0,        32'h80000000, 5'd4,  32'hF8000000);
    alu("slt_t",   4'd9,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd1);
    alu("slt_f",   4'd9,  32'd1,        32'hFFFFFFFF, 5'd0,  32'd0);
    alu("sltu",    4'd10, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0);
    alu("sltu_t",  4'd10, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd1);
    alu("lui",     4'd11, 32'd0,        32'h00001234, 5'd0,  32'h12340000);
    alu("op12",    4'd12, 32'd7,        32'd9,        5'd3,  32'hFFFFFFFF);
    alu("op15",    4'd15, 32'd7,        32'd9,        5'd3,  32'hFFFFFFFF);

    A = 32'h55; B = 32'h55; #1;
    chk("equal_t", 64'(Equal), 64'(1));
    B = 32'h54; #1;
    chk("equal_f", 64'(Equal), 64'(0));

    alu("ovf_add", 4'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000);
`ifdef ALU_OVF_EN
    chk("ovf_add_flag", 64'(Overflow), 64'(1));
    alu("ovf_sub", 4'd1, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF);
    chk("ovf_sub_flag", 64'(Overflow), 64'(1));
    alu("ovf_or", 4'd2, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h7FFFFFFF);
    chk("ovf_or_flag", 64'(Overflow), 64'(0));
`else
    chk("ovf_off_flag", 64'(Overflow), 64'(0));
`endif
    alu("ovf_none", 4'd0, 32'd5, 32'd3, 5'd0, 32'd8);
    chk("ovf_none_flag", 64'(Overflow), 64'(0));

    // Move-to ops
    @(posedge clk); #1;
    A = 32'hAAAA5555; MDOp = 3'd4; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("mthi_hi", 64'(HI), 64'(32'hAAAA5555));
    chk("mthi_busy", 64'(Busy), 64'(0));
    A = 32'h12345678; MDOp = 3'd5; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("mtlo_lo", 64'(LO), 64'(32'h12345678));
    chk("mtlo_hi_kept", 64'(HI), 64'(32'hAAAA5555));
    hi_m = 32'hAAAA5555; lo_m = 32'h12345678;

    // MDU computing ops
    mdu("mult",  3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 1'b0);
    mdu("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0);
    mdu("div",   3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
    mdu("divu0", 3'd3, 32'd7,        32'd0, hi_m,         lo_m,         10, 1'b1);
    mdu("divmn", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 1'b0);
    mdu("divu",  3'd3, 32'd100,      32'd7, 32'd2,        32'd14,       10, 1'b0);
    mdu("b2b",   3'd1, 32'd3,        32'd4, 32'd0,        32'd12,       5, 1'b0);

    // Reset while MULT is in flight
    A = 32'h7FFFFFFF; B = 32'h7FFFFFFF; MDOp = 3'd0; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    chk("abort_busy_rise", 64'(Busy), 64'(1));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_hi", 64'(HI), 64'(0));
    chk("abort_lo", 64'(LO), 64'(0));
    repeat (8) @(posedge clk);
    #1;
    chk("abort_late_busy", 64'(Busy), 64'(0));
    chk("abort_late_hi", 64'(HI), 64'(0));
    chk("abort_late_lo", 64'(LO), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
